shift_add_multiplier: RTL
=========================

// Module: shift_add_multiplier
// PURPOSE
//  Sequential radix-2 shift-add multiplier. It implements the user-multiplier side of the
//  multiplier-unit contract (CLK, input_1, input_2, accuracy -> busy, result).
//  It returns the low 32 bits of input_1*input_2, which are identical for signed and unsigned operands.
//  The execute-stage multiplier unit instantiates it and stalls the core while busy=1.
// PARAMETERS
//  EARLY_EXIT  1  1: stop iterating when the remaining multiplier bits are all zero; 0: always 32 iterations
// PORTS
//  CLK       in   1   core clock; all state updates on the rising edge
//  reset     in   1   synchronous, active-high reset
//  input_1   in   32  multiplicand
//  input_2   in   32  multiplier
//  accuracy  in   8   approximation level; used only with APPROX_MUL_EN, may be Z otherwise
//  busy      out  1   operation pending or in progress; combinational (Mealy)
//  result    out  32  registered low 32 bits of the last completed product
// BEHAVIOUR
//  - State: FSM {IDLE, CALC}; regs mcand[31:0], mplier[31:0], acc[31:0], cnt[5:0],
//    last_1, last_2 (operands of the last accepted operation).
//  - Reset (one edge): state=IDLE, result=0, acc=0, cnt=0, last_1=last_2=0.
//    busy=0 whenever the inputs match last_* (e.g. 0,0 after reset).
//  - No start strobe. A new operation is requested when state=IDLE and {input_1,input_2} != {last_1,last_2}.
//  - busy = (state==CALC) | new_request. It asserts in the same cycle the new operands appear.
//  - IDLE with new_request, at the next edge:
//    mcand=input_1, mplier=input_2, acc=0, cnt=0, last_*=inputs, state=CALC.
//  - CALC, each edge:
//    if mplier[0] then acc += mcand (mod 2^32); mcand <<= 1; mplier >>= 1; cnt += 1.
//  - CALC exit: the iteration where cnt==31, or (EARLY_EXIT and the shifted mplier==0).
//    On exit, result is written with the final acc and state=IDLE. busy falls in the following cycle.
//  - Latency: 1 load edge + N CALC edges.
//    N = 32 when EARLY_EXIT=0; otherwise N = max(1, msb_index(input_2)+1).
//    result is valid and busy=0 in cycle 1+N after the operands appear.
//  - Input changes during CALC are ignored (operands already latched).
//    On return to IDLE, if the inputs now differ from last_*, the next operation starts immediately,
//    so busy never drops for that cycle.
//  - Back-to-back identical operands: no restart, busy stays 0, result held.
//  - result holds its value between operations and changes only at CALC exit or reset.
//  - Reset mid-CALC: operation aborted, result=0, busy=0 unless the inputs differ from 0,0.
//  - Overflow above bit 31 is discarded; there is no sign handling, because two's-complement low bits are exact.
// CONFIGURATION
//  APPROX_MUL_EN defined:
//    - K = accuracy[4:0]; accuracy[7:5] are ignored.
//    - At load, mplier = input_2 & ~((1<<K)-1), i.e. the K low partial products are dropped. K=0 gives an exact result.
//    - accuracy is included in the change compare (a last_acc register is added).
//  APPROX_MUL_EN undefined:
//    - accuracy is unused and may float (Z).
//    - The result is always exact, and no last_acc register exists.
// TESTING
//  1. reset=1 for 2 cycles, inputs 0/0 -> busy=0, result=0x00000000; busy stays 0 after release.
//  2. EARLY_EXIT=1, input_1=7, input_2=6 -> busy=1 in cycle 0, N=3, result=42 and busy=0 in cycle 4.
//  3. 0xFFFFFFFF * 0xFFFFFFFF -> 32 CALC cycles, result=0x00000001.
//  4. 0xFFFFFFFD * 5 -> result=0xFFFFFFF1 (-15); then hold the same operands -> busy remains 0, result unchanged.
//  5. 3 * 0x80000000, reset pulsed on CALC cycle 10 -> result=0 and busy=0 in the cycle after the reset edge;
//     re-apply the operands -> result=0x80000000 after 33 cycles.
//  6. APPROX_MUL_EN, accuracy=4, 7 * 0x1F -> result=112 (exact 217).
//     Then accuracy=0 with the same operands -> restarts, result=217.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential radix-2 shift-add multiplier.
// Returns the low 32 bits of input_1*input_2. The same low bits are correct
// for signed and unsigned operands. There is no start strobe: a change in the
// operands while IDLE starts a new operation. busy is combinational.
// Optional feature macro: APPROX_MUL_EN. When it is defined, accuracy[4:0]
// gives the number of low multiplier bits to drop at load time.
module shift_add_multiplier #(
  parameter int EARLY_EXIT = 1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] input_1,
  input  logic [31:0] input_2,
  input  logic [7:0]  accuracy,
  output logic        busy,
  output logic [31:0] result
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t      state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [5:0]  cnt;
  logic [31:0] last_1;
  logic [31:0] last_2;

  logic        new_request;
  logic [31:0] load_mplier;
  logic [31:0] acc_next;
  logic [31:0] mplier_next;
  logic        done;

`ifdef APPROX_MUL_EN
  logic [4:0]  last_acc;
  logic [4:0]  acc_k;
  logic [2:0]  unused_accuracy_hi;

  // Clear the K low bits, which drops the K smallest partial products.
  function automatic logic [31:0] keep_mask(input logic [4:0] k);
    keep_mask = ~((32'd1 << k) - 32'd1);
  endfunction

  assign acc_k              = accuracy[4:0];
  assign unused_accuracy_hi = accuracy[7:5];
  assign new_request        = (state == IDLE) &&
                              ({input_1, input_2, acc_k} != {last_1, last_2, last_acc});
  assign load_mplier        = input_2 & keep_mask(acc_k);
`else
  logic [7:0]  unused_accuracy;

  assign unused_accuracy = accuracy;
  assign new_request     = (state == IDLE) && ({input_1, input_2} != {last_1, last_2});
  assign load_mplier     = input_2;
`endif

  // One iteration of the shift-add step. The exit condition looks at the
  // shifted multiplier, so early exit happens on the last useful bit.
  always_comb begin
    acc_next    = mplier[0] ? (acc + mcand) : acc;
    mplier_next = mplier >> 1;
    done        = (cnt == 6'd31) || ((EARLY_EXIT != 0) && (mplier_next == 32'd0));
  end

  assign busy = (state == CALC) || new_request;

  // FSM: load operands on a new request, then iterate until done.
  // Operand changes during CALC are ignored because the operands are already latched.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state  <= IDLE;
      result <= 32'd0;
      acc    <= 32'd0;
      cnt    <= 6'd0;
      last_1 <= 32'd0;
      last_2 <= 32'd0;
`ifdef APPROX_MUL_EN
      last_acc <= 5'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (new_request) begin
            mcand  <= input_1;
            mplier <= load_mplier;
            acc    <= 32'd0;
            cnt    <= 6'd0;
            last_1 <= input_1;
            last_2 <= input_2;
`ifdef APPROX_MUL_EN
            last_acc <= acc_k;
`endif
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          cnt    <= cnt + 6'd1;
          if (done) begin
            result <= acc_next;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
